// File: rtl/data_mem_responder.sv
// ============================================================================
// Module   : data_mem_responder
// Brief    : Queued load/store responder over a small word-addressed memory,
//            servicing one request at a time with fixed access latency.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module data_mem_responder #(
    parameter int DATA_WIDTH      = 16,
    parameter int ADDR_WIDTH      = 4,
    parameter int THREAD_ID_WIDTH = 2,
    parameter int LATENCY         = 2,
    parameter int FIFO_DEPTH      = 4
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       req_valid,
    output logic                       req_ready,
    input  logic                       req_write,
    input  logic [ADDR_WIDTH-1:0]      req_addr,
    input  logic [DATA_WIDTH-1:0]      req_wdata,
    input  logic [THREAD_ID_WIDTH-1:0] req_thread,
    output logic                       rsp_valid,
    input  logic                       rsp_ready,
    output logic                       rsp_write,
    output logic [DATA_WIDTH-1:0]      rsp_rdata,
    output logic [THREAD_ID_WIDTH-1:0] rsp_thread,
    output logic [3:0]                 pending
);

    localparam int         c_ptr_w   = $clog2(FIFO_DEPTH);
    localparam int         c_entry_w = 1 + ADDR_WIDTH + DATA_WIDTH + THREAD_ID_WIDTH;
    localparam int         c_words   = 1 << ADDR_WIDTH;
    localparam logic [3:0] c_lat_m1  = 4'(LATENCY - 1);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_ACCESS  = 2'd1,
        S_RESPOND = 2'd2
    } state_t;

    state_t r_state;

    logic [c_entry_w-1:0]       r_fifo [FIFO_DEPTH];
    logic [c_ptr_w:0]           r_wr_ptr;
    logic [c_ptr_w:0]           r_rd_ptr;
    logic [DATA_WIDTH-1:0]      r_mem [c_words];

    logic                       r_svc_write;
    logic [ADDR_WIDTH-1:0]      r_svc_addr;
    logic [DATA_WIDTH-1:0]      r_svc_wdata;
    logic [THREAD_ID_WIDTH-1:0] r_svc_thread;
    logic [3:0]                 r_cnt;

    logic [c_ptr_w:0]           w_count;
    logic                       w_empty;
    logic                       w_full;
    logic                       w_push;
    logic                       w_pop;
    logic                       w_access;
    logic                       w_head_write;
    logic [ADDR_WIDTH-1:0]      w_head_addr;
    logic [DATA_WIDTH-1:0]      w_head_wdata;
    logic [THREAD_ID_WIDTH-1:0] w_head_thread;

    // The extra MSB of each pointer separates full from empty when the low bits match.
    assign w_count = r_wr_ptr - r_rd_ptr;
    assign w_empty = (r_wr_ptr == r_rd_ptr);
    assign w_full  = (r_wr_ptr[c_ptr_w] != r_rd_ptr[c_ptr_w]) &&
                     (r_wr_ptr[c_ptr_w-1:0] == r_rd_ptr[c_ptr_w-1:0]);

    assign req_ready = !w_full;
    assign w_push    = req_valid && !w_full;
    assign w_pop     = !w_empty &&
                       ((r_state == S_IDLE) || ((r_state == S_RESPOND) && rsp_ready));
    assign w_access  = (r_state == S_ACCESS) && (r_cnt == c_lat_m1);

    assign {w_head_write, w_head_addr, w_head_wdata, w_head_thread} =
        r_fifo[r_rd_ptr[c_ptr_w-1:0]];

    assign pending = 4'(w_count) + {3'b000, (r_state != S_IDLE)};

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_fifo[r_wr_ptr[c_ptr_w-1:0]] <= {req_write, req_addr, req_wdata, req_thread};
        end
    end

    // Memory has no reset; the write is gated by state, which reset forces to IDLE.
    always_ff @(posedge clk) begin
        if (w_access && r_svc_write) begin
            r_mem[r_svc_addr] <= r_svc_wdata;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state      <= S_IDLE;
            r_cnt        <= 4'd0;
            r_svc_write  <= 1'b0;
            r_svc_addr   <= '0;
            r_svc_wdata  <= '0;
            r_svc_thread <= '0;
            rsp_valid    <= 1'b0;
            rsp_write    <= 1'b0;
            rsp_rdata    <= '0;
            rsp_thread   <= '0;
        end else begin
            if (w_pop) begin
                r_svc_write  <= w_head_write;
                r_svc_addr   <= w_head_addr;
                r_svc_wdata  <= w_head_wdata;
                r_svc_thread <= w_head_thread;
            end
            case (r_state)
                S_IDLE: begin
                    if (w_pop) begin
                        r_cnt   <= 4'd0;
                        r_state <= S_ACCESS;
                    end
                end
                S_ACCESS: begin
                    r_cnt <= r_cnt + 4'd1;
                    if (w_access) begin
                        rsp_valid  <= 1'b1;
                        rsp_write  <= r_svc_write;
                        rsp_thread <= r_svc_thread;
                        rsp_rdata  <= r_svc_write ? '0 : r_mem[r_svc_addr];
                        r_state    <= S_RESPOND;
                    end
                end
                S_RESPOND: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        if (w_pop) begin
                            r_cnt   <= 4'd0;
                            r_state <= S_ACCESS;
                        end else begin
                            r_state <= S_IDLE;
                        end
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_data_mem_responder.sv
// ============================================================================
// Module   : tb_data_mem_responder
// Brief    : Directed bench for data_mem_responder with a queue-level model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_data_mem_responder;

    localparam int c_depth = 4;
    localparam int c_lat   = 2;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_write = 1'b0;
    logic [3:0]  req_addr = '0;
    logic [15:0] req_wdata = '0;
    logic [1:0]  req_thread = '0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b1;
    logic        rsp_write;
    logic [15:0] rsp_rdata;
    logic [1:0]  rsp_thread;
    logic [3:0]  pending;

    data_mem_responder dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_thread(req_thread),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_write(rsp_write),
        .rsp_rdata(rsp_rdata), .rsp_thread(rsp_thread), .pending(pending)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit          w;
        logic [3:0]  a;
        logic [15:0] d;
        logic [1:0]  t;
    } req_t;

    typedef struct {
        bit          w;
        logic [15:0] d;
        logic [1:0]  t;
    } rsp_t;

    int total = 0;
    int bad   = 0;

    // Queue-level model: a waiting list, one request in service with a countdown.
    req_t        m_q[$];
    req_t        m_cur;
    bit          m_busy = 0;
    bit          m_pres = 0;
    int          m_rem  = 0;
    bit          m_exp_w = 0;
    logic [15:0] m_exp_d = '0;
    logic [1:0]  m_exp_t = '0;
    logic [15:0] m_mem [16];

    rsp_t        log_q[$];
    int          n_acc = 0;

    logic [15:0] c_data [6] = '{16'h0A51, 16'h1B62, 16'h2C73, 16'h3D84, 16'h4E95, 16'h5FA6};

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
        total++;
        if (act !== want) begin
            bad++;
            $display("FAIL %s: got 0x%0h want 0x%0h at %0t", name, act, want, $time);
        end
    endtask

    task automatic model_step();
        bit   accept;
        req_t r;
        if (reset) begin
            m_q.delete();
            m_busy = 0; m_pres = 0; m_rem = 0;
            m_exp_w = 0; m_exp_d = '0; m_exp_t = '0;
            return;
        end
        accept = req_valid && (m_q.size() < c_depth);
        if (!m_busy) begin
            if (m_q.size() > 0) begin
                m_cur = m_q.pop_front(); m_busy = 1; m_rem = c_lat;
            end
        end else if (!m_pres) begin
            m_rem--;
            if (m_rem == 0) begin
                m_pres = 1; m_exp_w = m_cur.w; m_exp_t = m_cur.t;
                if (m_cur.w) begin
                    m_mem[m_cur.a] = m_cur.d; m_exp_d = '0;
                end else begin
                    m_exp_d = m_mem[m_cur.a];
                end
            end
        end else if (rsp_ready) begin
            m_pres = 0;
            if (m_q.size() > 0) begin
                m_cur = m_q.pop_front(); m_rem = c_lat;
            end else begin
                m_busy = 0;
            end
        end
        if (accept) begin
            r.w = req_write; r.a = req_addr; r.d = req_wdata; r.t = req_thread;
            m_q.push_back(r);
        end
    endtask

    initial forever begin
        @(posedge clk or posedge reset);
        model_step();
    end

    // Compare against the model every cycle, away from the rising edge.
    initial forever begin
        rsp_t e;
        @(negedge clk);
        check("req_ready", {31'd0, req_ready}, {31'd0, (m_q.size() < c_depth)});
        check("pending", {28'd0, pending}, m_q.size() + int'(m_busy));
        check("rsp_valid", {31'd0, rsp_valid}, {31'd0, m_pres});
        if (m_pres || reset) begin
            check("rsp_write", {31'd0, rsp_write}, {31'd0, m_exp_w});
            check("rsp_rdata", {16'd0, rsp_rdata}, {16'd0, m_exp_d});
            check("rsp_thread", {30'd0, rsp_thread}, {30'd0, m_exp_t});
        end
        if (!reset && req_valid && req_ready) n_acc++;
        if (!reset && rsp_valid && rsp_ready) begin
            e.w = rsp_write; e.d = rsp_rdata; e.t = rsp_thread;
            log_q.push_back(e);
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic issue(input bit w, input logic [3:0] a, input logic [15:0] d, input logic [1:0] t);
        int  n = 0;
        bit  got = 0;
        req_write = w; req_addr = a; req_wdata = d; req_thread = t; req_valid = 1'b1;
        while (!got && n < 50) begin
            @(negedge clk);
            if (req_ready) got = 1;
            n++;
        end
        total++;
        if (!got) begin
            bad++;
            $display("FAIL issue_timeout: got not-accepted want accepted at %0t", $time);
        end
        tick();
        req_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        while ((pending != 4'd0 || rsp_valid) && n < 200) begin
            tick();
            n++;
        end
        total++;
        if (n >= 200) begin
            bad++;
            $display("FAIL drain_timeout: got %0d cycles want <200", n);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_req_ready"}, {31'd0, req_ready}, 32'd1);
        check({tag, "_pending"}, {28'd0, pending}, 32'd0);
        check({tag, "_rsp_valid"}, {31'd0, rsp_valid}, 32'd0);
        check({tag, "_rsp_write"}, {31'd0, rsp_write}, 32'd0);
        check({tag, "_rsp_rdata"}, {16'd0, rsp_rdata}, 32'd0);
        check({tag, "_rsp_thread"}, {30'd0, rsp_thread}, 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] hold_d;
        logic [1:0]  hold_t;

        tick(); tick();
        check_reset_outputs("rst0");
        reset = 1'b0;
        tick();

        // Store then load, with first-response latency pinned cycle by cycle.
        log_q.delete();
        issue(1'b1, 4'd3, 16'hBEEF, 2'd1);
        check("lat_e0", {31'd0, rsp_valid}, 32'd0);
        issue(1'b0, 4'd3, 16'h0000, 2'd2);
        check("lat_e1", {31'd0, rsp_valid}, 32'd0);
        tick();
        check("lat_e2", {31'd0, rsp_valid}, 32'd0);
        tick();
        check("lat_e3", {31'd0, rsp_valid}, 32'd1);
        check("lat_e3_write", {31'd0, rsp_write}, 32'd1);
        check("lat_e3_rdata", {16'd0, rsp_rdata}, 32'd0);
        wait_idle();
        check("sl_count", log_q.size(), 32'd2);
        if (log_q.size() == 2) begin
            check("sl0", {15'd0, log_q[0].w, log_q[0].d}, {15'd0, 1'b1, 16'h0000});
            check("sl0_t", {30'd0, log_q[0].t}, 32'd1);
            check("sl1", {15'd0, log_q[1].w, log_q[1].d}, {15'd0, 1'b0, 16'hBEEF});
            check("sl1_t", {30'd0, log_q[1].t}, 32'd2);
        end

        // Full queue under response back-pressure, then a single release.
        log_q.delete();
        rsp_ready = 1'b0;
        n_acc = 0;
        for (int i = 0; i < 6; i++) begin
            req_valid = 1'b1; req_write = 1'b0; req_addr = 4'd3;
            req_wdata = 16'(i); req_thread = 2'(i);
            tick();
        end
        req_valid = 1'b0;
        check("full_accepted", n_acc, 32'd5);
        check("full_ready", {31'd0, req_ready}, 32'd0);
        check("full_pending", {28'd0, pending}, 32'd5);
        check("model_pending", m_q.size() + int'(m_busy), 32'd5);
        check("bp_rdata", {16'd0, rsp_rdata}, 32'h0000BEEF);
        hold_d = rsp_rdata;
        hold_t = rsp_thread;
        for (int i = 0; i < 10; i++) begin
            tick();
            check("bp_valid", {31'd0, rsp_valid}, 32'd1);
            check("bp_stable", {14'd0, rsp_rdata, rsp_thread}, {14'd0, hold_d, hold_t});
        end
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        check("bp_one", log_q.size(), 32'd1);
        for (int i = 0; i < 5; i++) tick();
        check("bp_still_one", log_q.size(), 32'd1);
        rsp_ready = 1'b1;
        wait_idle();
        check("full_count", log_q.size(), 32'd5);
        if (log_q.size() == 5) begin
            for (int i = 0; i < 5; i++) begin
                check("full_order", {30'd0, log_q[i].t}, 32'(i % 4));
            end
        end

        // Alternating stores and loads, enough traffic to wrap the pointers.
        log_q.delete();
        for (int k = 0; k < 6; k++) begin
            issue(1'b1, 4'(k), c_data[k], 2'(k));
            issue(1'b0, 4'(k), 16'h0000, 2'(k + 1));
        end
        wait_idle();
        check("wrap_count", log_q.size(), 32'd12);
        if (log_q.size() == 12) begin
            for (int k = 0; k < 6; k++) begin
                check("wrap_store", {15'd0, log_q[2*k].w, log_q[2*k].d}, {15'd0, 1'b1, 16'h0000});
                check("wrap_load", {15'd0, log_q[2*k+1].w, log_q[2*k+1].d}, {15'd0, 1'b0, c_data[k]});
            end
        end

        // Reset during the access of a store; memory keeps its old value.
        issue(1'b1, 4'd7, 16'h1234, 2'd0);
        wait_idle();
        issue(1'b1, 4'd7, 16'h5678, 2'd1);
        req_valid = 1'b1; req_write = 1'b1; req_addr = 4'd7;
        req_wdata = 16'h9999; req_thread = 2'd2;
        tick();
        req_valid = 1'b0;
        reset = 1'b1;
        #1;
        check_reset_outputs("rst_mid");
        tick(); tick();
        reset = 1'b0;
        tick();
        log_q.delete();
        issue(1'b0, 4'd7, 16'h0000, 2'd3);
        wait_idle();
        check("rst_count", log_q.size(), 32'd1);
        if (log_q.size() == 1) begin
            check("rst_mem", {16'd0, log_q[0].d}, 32'h00001234);
            check("rst_thread", {30'd0, log_q[0].t}, 32'd3);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/data_mem_responder.md
DATA_MEM_RESPONDER -- requirements
Module: data_mem_responder

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 16, width of data words.
REQ-002 SHALL have parameter ADDR_WIDTH, default 4, word address width; the array holds 2^ADDR_WIDTH words.
REQ-003 SHALL have parameter THREAD_ID_WIDTH, default 2, width of the requesting-thread tag.
REQ-004 SHALL have parameter LATENCY, default 2, access cycles per request; legal range 1-15.
REQ-005 SHALL have parameter FIFO_DEPTH, default 4, request queue entries; must be a power of 2 and at least 2.
REQ-006 clk  input  1  clock; all state updates on rising edge.
REQ-007 reset  input  1  asynchronous, active-high reset.
REQ-008 req_valid  input  1  requester presents a load/store.
REQ-009 req_ready  output  1  queue can accept a request this cycle.
REQ-010 req_write  input  1  1 = store, 0 = load.
REQ-011 req_addr  input  ADDR_WIDTH  word address.
REQ-012 req_wdata  input  DATA_WIDTH  store data.
REQ-013 req_thread  input  THREAD_ID_WIDTH  tag of the issuing thread.
REQ-014 rsp_valid  output  1  response presented.
REQ-015 rsp_ready  input  1  requester accepts the response.
REQ-016 rsp_write  output  1  echo of req_write for this response.
REQ-017 rsp_rdata  output  DATA_WIDTH  load data; 0 for store responses.
REQ-018 rsp_thread  output  THREAD_ID_WIDTH  echo of req_thread.
REQ-019 pending  output  4  requests queued plus the one in service.

Function
REQ-020 Request transfer SHALL occur on a rising edge with req_valid=1 and req_ready=1; the request is pushed into the FIFO tail.
REQ-021 req_ready SHALL be 1 exactly when the FIFO is not full; a pop on the same edge does not make a full FIFO accept a push.
REQ-022 FSM SHALL have states IDLE, ACCESS and RESPOND.
REQ-023 IDLE: if the FIFO is non-empty, SHALL pop the head into the service register, clear the cycle counter and go to ACCESS. If the FIFO is empty, SHALL stay in IDLE; there is no push-to-service bypass.
REQ-024 ACCESS: SHALL increment the counter each edge. On the edge where counter == LATENCY-1, SHALL perform the access and go to RESPOND.
REQ-025 Access: a store SHALL write wdata to mem[addr] and set rsp_rdata=0; a load SHALL capture mem[addr] into rsp_rdata.
REQ-026 RESPOND: rsp_valid=1 and rsp_write, rsp_rdata and rsp_thread SHALL be held stable until an edge with rsp_ready=1.
REQ-027 On that response edge, SHALL pop the next request and go to ACCESS if the FIFO is non-empty, else go to IDLE.
REQ-028 Latency: a request accepted at edge E into an idle, empty block SHALL show rsp_valid=1 after edge E+LATENCY+1.
REQ-029 Requests SHALL be serviced strictly in order, one at a time; a store is visible to every later load.
REQ-030 pending SHALL equal the FIFO count plus 1 while in ACCESS or RESPOND; simultaneous push and pop SHALL leave the FIFO count unchanged.
REQ-031 FIFO pointers SHALL wrap modulo FIFO_DEPTH, and full/empty SHALL be distinguished by an extra pointer bit.
REQ-032 Changes to req_* inputs while req_ready=0 SHALL have no effect.

Reset
REQ-033 Reset SHALL force the state to IDLE and empty the FIFO; pending=0, rsp_valid=0, rsp_write=0, rsp_rdata=0, rsp_thread=0, req_ready=1.
REQ-034 Reset mid-ACCESS or mid-RESPOND SHALL drop the in-service and queued requests; a store not yet at its access edge SHALL not modify memory.
REQ-035 Memory contents SHALL not be affected by reset.

Verification
REQ-036 Store then load: store addr 3 data 0xBEEF thread 1 with rsp_ready=1, then load addr 3 thread 2 -> two responses in order: (write=1, rdata=0, thread=1) then (write=0, rdata=0xBEEF, thread=2); the first rsp_valid comes 3 cycles after acceptance.
REQ-037 Full queue: hold rsp_ready=0 and issue 6 back-to-back loads -> 5 accepted (4 queued plus 1 in service); req_ready=0 afterwards; pending=5.
REQ-038 Back-pressure: rsp_ready=0 for 10 cycles during RESPOND -> rsp_valid and data stable throughout; exactly one response is consumed on release.
REQ-039 Wrap-around: 12 alternating stores/loads to addrs 0-5 with rsp_ready=1 -> every load returns the latest stored value, and the FIFO pointers wrap at least twice.
REQ-040 Reset mid-operation: assert reset in ACCESS of a store to addr 7 (old value 0x1234) -> addr 7 reads back 0x1234 after reset; all outputs match REQ-033 immediately on reset assertion.
